spiker_result_capture: RTL
==========================

SPIKER_RESULT_CAPTURE -- requirements
Module: spiker_result_capture

Interface
REQ-001 SHALL have parameter WIDTH, default 32, word width of one result register.
REQ-002 SHALL have parameter N_REG, default 24, words per result frame.
REQ-003 SHALL have parameter DATA_WIDTH, default WIDTH*N_REG, frame bus width; elaboration error if DATA_WIDTH != WIDTH*N_REG.
REQ-004 SHALL have parameter N_BUF, default 2, frame buffer depth; legal range 1..8.
REQ-005 SHALL have parameter CNT_W, default 16, width of frame and overflow counters.
REQ-006 SHALL have port clk_i  in  1  clock, all logic on rising edge.
REQ-007 SHALL have port rst_ni  in  1  reset, asynchronous, active-low.
REQ-008 SHALL have port clear_i  in  1  synchronous flush of buffers and counters.
REQ-009 SHALL have port data_i  in  DATA_WIDTH  result frame; word k at bits [(k+1)*WIDTH-1 : k*WIDTH].
REQ-010 SHALL have port valid_i  in  1  frame present on data_i.
REQ-011 SHALL have port ready_o  out  1  a free buffer exists.
REQ-012 SHALL have port rd_idx_i  in  $clog2(N_REG)  word select within the oldest frame.
REQ-013 SHALL have port rd_data_o  out  WIDTH  selected word of the oldest stored frame.
REQ-014 SHALL have port rd_valid_o  out  1  at least one frame stored.
REQ-015 SHALL have port release_i  in  1  single-cycle pulse; software done with the oldest frame.
REQ-016 SHALL have port level_o  out  $clog2(N_BUF+1)  stored frame count.
REQ-017 SHALL have port done_irq_o  out  1  one-cycle pulse per accepted frame.
REQ-018 SHALL have port frame_cnt_o  out  CNT_W  accepted frames, wrapping.
REQ-019 SHALL have port ovf_cnt_o  out  CNT_W  dropped frames, saturating.

Function
REQ-020 SHALL store frames in an N_BUF-deep circular buffer of DATA_WIDTH entries, with write pointer wp, read pointer rp and count level_o.
REQ-021 SHALL accept a frame when valid_i && ready_o at a rising edge: latch data_i into entry wp, advance wp modulo N_BUF, increment level_o.
REQ-022 SHALL drive ready_o = (level_o != N_BUF), combinationally from registered state only, never from valid_i.
REQ-023 SHALL make an accepted frame readable one cycle after acceptance when it is the oldest frame.
REQ-024 SHALL drive rd_data_o combinationally as word rd_idx_i of entry rp, and drive 0 when rd_idx_i >= N_REG or level_o == 0.
REQ-025 SHALL drive rd_valid_o = (level_o != 0).
REQ-026 SHALL, on release_i with level_o != 0, advance rp modulo N_BUF and decrement level_o; release_i with level_o == 0 SHALL be ignored.
REQ-027 SHALL, on accept and valid release in the same cycle, advance both pointers and leave level_o unchanged.
REQ-028 SHALL, on valid_i with level_o == N_BUF, drop the frame, leave stored data unchanged, and increment ovf_cnt_o, saturating at 2^CNT_W-1.
REQ-029 SHALL, when full and release_i coincides with valid_i, drop that frame (ready_o is low) and count it as overflow.
REQ-030 SHALL assert done_irq_o for exactly the cycle after each accept.
REQ-031 SHALL increment frame_cnt_o on each accept, wrapping from 2^CNT_W-1 to 0.
REQ-032 SHALL, on clear_i, zero wp, rp, level_o, frame_cnt_o, ovf_cnt_o and done_irq_o; clear_i SHALL take priority over an accept or release in the same cycle, and buffer contents need not be zeroed.
REQ-033 SHALL, with N_BUF == 1, behave as a single hold register: accept only while empty, and free it on release.

Reset
REQ-034 SHALL, while rst_ni is low, force wp=0, rp=0, level_o=0, ready_o=1, rd_valid_o=0, rd_data_o=0, done_irq_o=0, frame_cnt_o=0, ovf_cnt_o=0.
REQ-035 SHALL zero all buffer entries on reset.
REQ-036 SHALL, when reset asserts mid-operation, discard pending frames, and SHALL accept nothing on the first edge after deassertion unless valid_i is high at that edge.

Verification
REQ-037 Bench SHALL cover: reset, then one frame with word k = 0x1000+k, valid 1 cycle -> done_irq_o pulses once, level_o=1, rd_idx_i=5 gives rd_data_o=0x1005, frame_cnt_o=1.
REQ-038 Bench SHALL cover: N_BUF=2, three back-to-back frames A,B,C without release -> ready_o low after B, C dropped, ovf_cnt_o=1, rd_data_o reads frame A.
REQ-039 Bench SHALL cover: level_o=1, accept and release in the same cycle -> level_o stays 1, and the next read returns the new frame.
REQ-040 Bench SHALL cover: release_i pulses with level_o=0 -> level_o stays 0 and no pointer moves (a later accept reads back correctly).
REQ-041 Bench SHALL cover: rd_idx_i = N_REG (when representable) -> rd_data_o = 0; clear_i with level_o=2 -> level_o=0, counters 0, ready_o=1 next cycle.
REQ-042 Bench SHALL cover: rst_ni pulsed low for 1 cycle while full -> all outputs take their REQ-034 values asynchronously, and ovf_cnt_o saturation is checked with CNT_W=2 after 5 drops (value 3).

Source files
------------

// File: rtl/spiker_result_capture.sv
// Result capture for the spiker core: an N_BUF-deep circular buffer of result frames,
// with word-addressed readout of the oldest frame, accept/overflow counters and a done pulse.
module spiker_result_capture #(
    parameter  int WIDTH      = 32,
    parameter  int N_REG      = 24,
    parameter  int DATA_WIDTH = WIDTH * N_REG,
    parameter  int N_BUF      = 2,
    parameter  int CNT_W      = 16,
    localparam int IDX_W      = (N_REG > 1) ? $clog2(N_REG) : 1,
    localparam int LVL_W      = $clog2(N_BUF + 1)
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  clear_i,
    input  logic [DATA_WIDTH-1:0] data_i,
    input  logic                  valid_i,
    output logic                  ready_o,
    input  logic [IDX_W-1:0]      rd_idx_i,
    output logic [WIDTH-1:0]      rd_data_o,
    output logic                  rd_valid_o,
    input  logic                  release_i,
    output logic [LVL_W-1:0]      level_o,
    output logic                  done_irq_o,
    output logic [CNT_W-1:0]      frame_cnt_o,
    output logic [CNT_W-1:0]      ovf_cnt_o
);

    localparam int PTR_W = (N_BUF > 1) ? $clog2(N_BUF) : 1;

    if (DATA_WIDTH != WIDTH * N_REG) begin : g_bad_data_width
        $error("spiker_result_capture: DATA_WIDTH must equal WIDTH*N_REG");
    end
    if (N_BUF < 1 || N_BUF > 8) begin : g_bad_n_buf
        $error("spiker_result_capture: N_BUF must be in 1..8");
    end

    typedef logic [N_REG-1:0][WIDTH-1:0] frame_t;

    frame_t           mem_q [N_BUF];
    logic [PTR_W-1:0] wp_q, wp_d, rp_q, rp_d;
    logic [LVL_W-1:0] level_q, level_d;
    logic [CNT_W-1:0] frame_cnt_q, frame_cnt_d, ovf_cnt_q, ovf_cnt_d;
    logic             done_irq_q, done_irq_d;
    logic             accept, release_ok, drop;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(N_BUF - 1)) ? '0 : p + 1'b1;
    endfunction

    // Handshake depends only on registered state, so ready_o never combinationally follows valid_i.
    assign ready_o    = (level_q != LVL_W'(N_BUF));
    assign rd_valid_o = (level_q != '0);
    assign accept     = valid_i && ready_o;
    assign release_ok = release_i && rd_valid_o;
    assign drop       = valid_i && !ready_o;

    assign level_o     = level_q;
    assign done_irq_o  = done_irq_q;
    assign frame_cnt_o = frame_cnt_q;
    assign ovf_cnt_o   = ovf_cnt_q;

    always_comb begin
        rd_data_o = '0;
        if (rd_valid_o && int'(rd_idx_i) < N_REG) begin
            rd_data_o = mem_q[rp_q][rd_idx_i];
        end
    end

    // NOTE: every next-state signal gets its hold value first, so no path can infer a latch.
    always_comb begin
        wp_d        = wp_q;
        rp_d        = rp_q;
        level_d     = level_q;
        frame_cnt_d = frame_cnt_q;
        ovf_cnt_d   = ovf_cnt_q;
        done_irq_d  = 1'b0;
        if (clear_i) begin
            wp_d        = '0;
            rp_d        = '0;
            level_d     = '0;
            frame_cnt_d = '0;
            ovf_cnt_d   = '0;
        end else begin
            done_irq_d = accept;
            if (accept) begin
                wp_d        = ptr_inc(wp_q);
                frame_cnt_d = frame_cnt_q + 1'b1;
            end
            if (release_ok) begin
                rp_d = ptr_inc(rp_q);
            end
            if (accept && !release_ok) begin
                level_d = level_q + 1'b1;
            end else if (!accept && release_ok) begin
                level_d = level_q - 1'b1;
            end
            if (drop && ovf_cnt_q != '1) begin
                ovf_cnt_d = ovf_cnt_q + 1'b1;
            end
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wp_q        <= '0;
            rp_q        <= '0;
            level_q     <= '0;
            frame_cnt_q <= '0;
            ovf_cnt_q   <= '0;
            done_irq_q  <= 1'b0;
        end else begin
            wp_q        <= wp_d;
            rp_q        <= rp_d;
            level_q     <= level_d;
            frame_cnt_q <= frame_cnt_d;
            ovf_cnt_q   <= ovf_cnt_d;
            done_irq_q  <= done_irq_d;
        end
    end

    // NOTE: the frame store is deliberately reset so stale results never survive a reset.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int b = 0; b < N_BUF; b++) begin
                mem_q[b] <= '0;
            end
        end else if (accept && !clear_i) begin
            mem_q[wp_q] <= data_i;
        end
    end

endmodule
